mmu_ctrl: RTL and testbench
===========================

# mmu_ctrl

Sequencing controller for the 4×4 `mac_array` matrix-multiply datapath. It accepts operand matrices A and B as a byte stream over a valid/ready handshake and assembles them into the array's flat operand buses. It then runs the array until `mac_done` and returns the 16 accumulated results as a 32-bit word stream. It sits between the system-side data mover and `mac_array` and owns that array's reset and enable.

## Interface
- `N`, 4, matrix dimension (fixed 4 for `mac_array`).
- `DATA_W`, 8, operand element width.
- `ACC_W`, 32, result element width.
- `TIMEOUT_CYCLES`, 256, compute watchdog limit (used only with `MMU_CTRL_TIMEOUT_EN`).

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operand byte valid.
- `in_ready`  out  1  operand byte accepted when `in_valid & in_ready`.
- `in_data`  in  DATA_W  operand byte; A row-major, then B row-major.
- `out_valid`  out  1  result word valid.
- `out_ready`  in  1  result sink ready.
- `out_data`  out  ACC_W  result word C[i][j], row-major.
- `out_last`  out  1  marks C[N-1][N-1].
- `busy`  out  1  state != IDLE.
- `err`  out  1  sticky compute-timeout flag.
- `mac_reset`  out  1  active-high reset to `mac_array`.
- `mac_enable`  out  1  enable to `mac_array`.
- `mac_a`, `mac_b`  out  N*N*DATA_W  element [i][j] at bits `(i*N+j)*DATA_W +: DATA_W`.
- `mac_c`  in  N*N*ACC_W  same packing, using ACC_W.
- `mac_done`  in  1  level; results on `mac_c` are valid while high.

## Operation
- FSM states: IDLE, LOAD, COMPUTE, DRAIN. All outputs are decoded from registered state and registers.
- IDLE:
  - `in_ready=1`.
  - An accepted byte is written to A[0][0], sets index=1, clears `err`, and moves to LOAD.
- LOAD:
  - `in_ready=1`.
  - Index 0..15 writes A and 16..31 writes B; index increments per handshake.
  - Gaps in `in_valid` hold the index.
  - The handshake at index 31 moves to COMPUTE.
- COMPUTE:
  - `mac_reset=0` and `mac_enable=1`; `in_ready=0`.
  - On the first cycle with `mac_done=1`, all of `mac_c` is captured into the result registers, and the state moves to DRAIN.
- DRAIN:
  - `out_valid=1`, with `out_data` set to result[k]. k starts at 0 and increments per handshake.
  - `out_last` is asserted at k=15; that handshake returns the FSM to IDLE.
- `mac_reset=1` and `mac_enable=0` in every state except COMPUTE, so the accumulators are always clean at COMPUTE entry.
- `mac_done` is ignored outside COMPUTE.
- No arithmetic is performed; results pass through unmodified at ACC_W.

## Timing
- Reset values: state IDLE, `in_ready=1`, `out_valid=0`, `out_last=0`, `out_data=0`, `busy=0`, `err=0`, `mac_reset=1`, `mac_enable=0`, `mac_a`/`mac_b`/results=0, counters=0.
- Latency:
  - The 32nd byte accepted at cycle t puts the FSM in COMPUTE at t+1.
  - `mac_done` high at cycle u gives `out_valid=1` at u+1.
  - The last output handshake at cycle v gives `in_ready=1` (IDLE) at v+1.
- With `out_ready` held high, the drain runs at 1 word per cycle and takes 16 cycles.
- While `out_valid=1 & out_ready=0`, `out_data` and `out_last` hold stable.
- Reset mid-operation: all registers return to their reset values immediately (asynchronous), and partial loads and drains are discarded.

## Configuration
- `MMU_CTRL_TIMEOUT_EN` defined:
  - A cycle counter clears on COMPUTE entry and increments each COMPUTE cycle while `mac_done=0`.
  - When it reaches TIMEOUT_CYCLES-1 without `mac_done`, the block sets `err=1` and returns to IDLE without capture or drain.
- Not defined:
  - There is no counter; COMPUTE waits indefinitely.
  - `err` is tied to 0.

## Structure
- Shared package `mmu_pkg`: state enum, N/DATA_W/ACC_W constants, and the flat-index function `(i*N+j)`.
- One sub-module, `mmu_out_serializer`: holds the result registers and k counter, and drives `out_valid`/`out_data`/`out_last`.

## Test plan
- Stream A={5,2,7,1, 3,6,4,8, 9,0,2,5, 1,3,8,6} then B={2,7,1,4, 5,0,6,3, 3,8,2,1, 4,1,9,5} with a real `mac_array` -> 16 words; the first four are 45,92,40,38, and the last is 51 with `out_last=1`.
- Toggle `out_ready` 1/0 each cycle during the drain -> `out_data` stable while stalled, exactly 16 handshakes, order unchanged.
- Insert 3 idle cycles between loaded bytes -> index holds; `mac_enable` rises exactly 1 cycle after the 32nd handshake.
- Pulse `reset_n` low for 2 cycles after 5 output words -> all outputs at reset values; the next full load yields correct results.
- With `MMU_CTRL_TIMEOUT_EN`, TIMEOUT_CYCLES=16 and `mac_done` stubbed to 0 -> `err=1` and IDLE after 16 COMPUTE cycles, no `out_valid`; `err` clears on the next first byte.
- Assert `mac_done=1` during LOAD -> ignored; the load completes and COMPUTE is entered normally.

Source files
------------

// File: rtl/mmu_pkg.sv
// mmu_pkg: shared state type, sizing constants and element indexing
// for the mmu_ctrl sequencer and its output serializer.
package mmu_pkg;

    localparam int MMU_N              = 4;
    localparam int MMU_DATA_W         = 8;
    localparam int MMU_ACC_W          = 32;
    localparam int MMU_TIMEOUT_CYCLES = 256;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LOAD    = 2'd1,
        S_COMPUTE = 2'd2,
        S_DRAIN   = 2'd3
    } state_t;

    // Row-major element position inside the mac_array flat buses.
    function automatic int flat_idx(input int i, input int j);
        return i * MMU_N + j;
    endfunction

endpackage

// File: rtl/mmu_out_serializer.sv
// mmu_out_serializer: captures the mac_array results and streams them
// out row-major as one ACC_W word per valid/ready handshake.
module mmu_out_serializer
    import mmu_pkg::*;
#(
    parameter int N     = MMU_N,
    parameter int ACC_W = MMU_ACC_W
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 i_capture,
    input  logic [N*N*ACC_W-1:0] i_mac_c,
    input  logic                 i_out_ready,
    output logic                 o_out_valid,
    output logic [ACC_W-1:0]     o_out_data,
    output logic                 o_out_last,
    output logic                 o_last_hs
);

    localparam int NE = N * N;
    localparam int KW = $clog2(NE);

    logic [NE*ACC_W-1:0] r_res;
    logic [KW-1:0]       r_k;
    logic                r_valid;
    logic                w_last;
    logic                w_hs;

    assign w_last    = r_valid & (r_k == KW'(NE - 1));
    assign w_hs      = r_valid & i_out_ready;
    assign o_last_hs = w_last & i_out_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_res   <= '0;
            r_k     <= '0;
            r_valid <= 1'b0;
        end else if (i_capture) begin
            r_res   <= i_mac_c;
            r_k     <= '0;
            r_valid <= 1'b1;
        end else if (w_hs) begin
            r_k <= r_k + KW'(1);
            if (w_last) begin
                r_valid <= 1'b0;
            end
        end
    end

    // Data is forced to zero outside a drain so idle buses stay quiet.
    assign o_out_valid = r_valid;
    assign o_out_data  = r_valid ? r_res[r_k*ACC_W +: ACC_W] : '0;
    assign o_out_last  = w_last;

endmodule

// File: rtl/mmu_ctrl.sv
// mmu_ctrl: loads A/B byte streams into mac_array, runs it, drains results.
// Optional compute watchdog is enabled with `define MMU_CTRL_TIMEOUT_EN.
module mmu_ctrl
    import mmu_pkg::*;
#(
    parameter int N              = MMU_N,
    parameter int DATA_W         = MMU_DATA_W,
    parameter int ACC_W          = MMU_ACC_W,
    parameter int TIMEOUT_CYCLES = MMU_TIMEOUT_CYCLES
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ACC_W-1:0]      out_data,
    output logic                  out_last,
    output logic                  busy,
    output logic                  err,
    output logic                  mac_reset,
    output logic                  mac_enable,
    output logic [N*N*DATA_W-1:0] mac_a,
    output logic [N*N*DATA_W-1:0] mac_b,
    input  logic [N*N*ACC_W-1:0]  mac_c,
    input  logic                  mac_done
);

    localparam int NE    = N * N;
    localparam int IDX_W = $clog2(2 * NE);
    localparam int POS_W = $clog2(NE);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [IDX_W-1:0]     r_idx;
    logic [NE*DATA_W-1:0] r_mac_a;
    logic [NE*DATA_W-1:0] r_mac_b;
    logic [POS_W-1:0]     w_pos;
    logic                 w_in_hs;
    logic                 w_load_last;
    logic                 w_capture;
    logic                 w_drain_last;
    logic                 w_timeout;

    assign w_in_hs     = in_valid & in_ready;
    assign w_load_last = w_in_hs & (r_idx == IDX_W'(2 * NE - 1));
    assign w_capture   = (r_state == S_COMPUTE) & mac_done;
    assign w_pos       = POS_W'(flat_idx(int'(r_idx[POS_W-1:0]) / N,
                                         int'(r_idx[POS_W-1:0]) % N));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_in_hs) w_state_nxt = S_LOAD;
            end
            S_LOAD: begin
                if (w_load_last) w_state_nxt = S_COMPUTE;
            end
            S_COMPUTE: begin
                if (mac_done) begin
                    w_state_nxt = S_DRAIN;
                end else if (w_timeout) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (w_drain_last) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Upper index half selects B; the index wraps to 0 after the last byte.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_idx   <= '0;
            r_mac_a <= '0;
            r_mac_b <= '0;
        end else if (w_in_hs) begin
            if (r_idx[IDX_W-1]) begin
                r_mac_b[w_pos*DATA_W +: DATA_W] <= in_data;
            end else begin
                r_mac_a[w_pos*DATA_W +: DATA_W] <= in_data;
            end
            r_idx <= w_load_last ? '0 : r_idx + IDX_W'(1);
        end
    end

`ifdef MMU_CTRL_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [TMO_W-1:0] r_tmo;
    logic             r_err;

    assign w_timeout = (r_state == S_COMPUTE) & ~mac_done &
                       (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tmo <= '0;
            r_err <= 1'b0;
        end else begin
            if (r_state != S_COMPUTE) begin
                r_tmo <= '0;
            end else if (!mac_done) begin
                r_tmo <= r_tmo + TMO_W'(1);
            end
            if (w_timeout) begin
                r_err <= 1'b1;
            end else if ((r_state == S_IDLE) && w_in_hs) begin
                r_err <= 1'b0;
            end
        end
    end

    assign err = r_err;
`else
    // Without the watchdog COMPUTE waits for mac_done indefinitely.
    assign w_timeout = (TIMEOUT_CYCLES < 0);
    assign err       = 1'b0;
`endif

    mmu_out_serializer #(
        .N     (N),
        .ACC_W (ACC_W)
    ) u_ser (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_capture   (w_capture),
        .i_mac_c     (mac_c),
        .i_out_ready (out_ready),
        .o_out_valid (out_valid),
        .o_out_data  (out_data),
        .o_out_last  (out_last),
        .o_last_hs   (w_drain_last)
    );

    assign in_ready   = (r_state == S_IDLE) | (r_state == S_LOAD);
    assign busy       = (r_state != S_IDLE);
    assign mac_enable = (r_state == S_COMPUTE);
    assign mac_reset  = (r_state != S_COMPUTE);
    assign mac_a      = r_mac_a;
    assign mac_b      = r_mac_b;

endmodule

// File: tb/tb_mmu_ctrl.sv
// tb_mmu_ctrl: random matrix loads through mmu_ctrl with a behavioural
// mac_array stand-in, results checked against a plain matrix product.
module tb_mmu_ctrl;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int AW = 32;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DW-1:0]     in_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [AW-1:0]     out_data;
    logic              out_last;
    logic              busy;
    logic              err;
    logic              mac_reset;
    logic              mac_enable;
    logic [N*N*DW-1:0] mac_a;
    logic [N*N*DW-1:0] mac_b;
    logic [N*N*AW-1:0] mac_c;
    logic              mac_done;

    int n_checks = 0;
    int n_errors = 0;

    int mA [16];
    int mB [16];
    int expC [16];
    int obs [16];

    logic force_done = 1'b0;
    logic stub_dead  = 1'b0;
    int   stub_lat   = 4;
    int   st_cnt;

    always #5 clk = ~clk;

    mmu_ctrl #(
        .N              (N),
        .DATA_W         (DW),
        .ACC_W          (AW),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .busy       (busy),
        .err        (err),
        .mac_reset  (mac_reset),
        .mac_enable (mac_enable),
        .mac_a      (mac_a),
        .mac_b      (mac_b),
        .mac_c      (mac_c),
        .mac_done   (mac_done)
    );

    // mac_array stand-in: product of the presented buses, done after stub_lat
    always_comb begin : mac_model
        logic [31:0] acc;
        mac_c = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                acc = '0;
                for (int k = 0; k < N; k++) begin
                    acc = acc + 32'(mac_a[(i*N+k)*DW +: DW]) *
                                32'(mac_b[(k*N+j)*DW +: DW]);
                end
                mac_c[(i*N+j)*AW +: AW] = acc;
            end
        end
    end

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) st_cnt <= 0;
        else if (mac_reset) st_cnt <= 0;
        else if (mac_enable) st_cnt <= st_cnt + 1;
    end

    assign mac_done = !stub_dead &&
                      (force_done || (!mac_reset && st_cnt >= stub_lat));

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic model();
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                expC[i*4+j] = 0;
                for (int k = 0; k < 4; k++)
                    expC[i*4+j] += mA[i*4+k] * mB[k*4+j];
            end
    endtask

    task automatic rand_mats();
        for (int i = 0; i < 16; i++) begin
            mA[i] = int'($urandom_range(0, 255));
            mB[i] = int'($urandom_range(0, 255));
        end
        stub_lat = int'($urandom_range(2, 12));
        model();
    endtask

    task automatic chk_reset(input string tag);
        check({tag, "_in_ready"}, in_ready, 1);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_last"}, out_last, 0);
        check({tag, "_out_data"}, out_data, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_mac_reset"}, mac_reset, 1);
        check({tag, "_mac_enable"}, mac_enable, 0);
        check({tag, "_mac_a_zero"}, mac_a == '0, 1);
        check({tag, "_mac_b_zero"}, mac_b == '0, 1);
    endtask

    // gapm: 0 back-to-back, 1 three idle cycles, 2 random gaps
    task automatic load_mats(input int gapm, input bit dn_pulse);
        int g;
        for (int i = 0; i < 32; i++) begin
            g = (gapm == 1) ? 3 : (gapm == 2) ? int'($urandom_range(0, 2)) : 0;
            if (i == 0) g = 0;
            for (int c = 0; c < g; c++) begin
                @(negedge clk);
                in_valid = 1'b0;
                in_data  = DW'($urandom);
            end
            @(negedge clk);
            force_done = dn_pulse && i >= 4 && i < 20;
            in_valid   = 1'b1;
            in_data    = (i < 16) ? DW'(mA[i]) : DW'(mB[i-16]);
            if (i == 0 || i == 31) check("in_ready_load", in_ready, 1);
            if (i == 1) check("err_clear", err, 0);
            if (i == 31) check("en_before_last", mac_enable, 0);
            if (dn_pulse && i == 20)
                check("done_ignored", {busy, out_valid, in_ready}, 3'b101);
        end
        @(negedge clk);
        in_valid   = 1'b0;
        force_done = 1'b0;
        check("en_after_last", mac_enable, 1);
        check("ready_compute", in_ready, 0);
    endtask

    // rmode: 0 ready high, 1 toggling, 2 random; stop: handshakes before abort
    task automatic run_drain(input int rmode, input int stop);
        int  k   = 0;
        int  cyc = 0;
        bit  dn;
        bit  rdy;
        while (!out_valid) begin
            if (cyc > 200) begin
                check("valid_timeout", out_valid, 1);
                return;
            end
            cyc++;
            dn = mac_done & mac_enable;
            @(negedge clk);
            if (dn) check("done_latency", out_valid, 1);
        end
        cyc = 0;
        while (k < 16) begin
            if (cyc > 200) begin
                check("drain_timeout", k, 16);
                out_ready = 1'b0;
                return;
            end
            cyc++;
            rdy = (rmode == 0) ? 1'b1 :
                  (rmode == 1) ? cyc[0] : 1'($urandom_range(0, 1));
            out_ready = rdy;
            check("out_valid", out_valid, 1);
            check("out_data", out_data, 64'(expC[k]));
            check("out_last", out_last, k == 15);
            obs[k] = int'(out_data);
            if (rdy) k++;
            @(negedge clk);
            if (k == stop) begin
                out_ready = 1'b0;
                return;
            end
        end
        out_ready = 1'b0;
        check("idle_in_ready", in_ready, 1);
        check("idle_busy", busy, 0);
        check("idle_out_valid", out_valid, 0);
    endtask

    initial begin
        int cyc;
        bit sawv;

        repeat (2) @(negedge clk);
        chk_reset("rst");
        reset_n = 1'b1;

        mA = '{5,2,7,1, 3,6,4,8, 9,0,2,5, 1,3,8,6};
        mB = '{2,7,1,4, 5,0,6,3, 3,8,2,1, 4,1,9,5};
        stub_lat = 6;
        model();
        load_mats(0, 1'b0);
        run_drain(0, -1);
        check("vec_c00", obs[0], 45);
        check("vec_c01", obs[1], 92);
        check("vec_c02", obs[2], 40);
        check("vec_c03", obs[3], 38);
        check("vec_c33", obs[15], 51);

        rand_mats();
        load_mats(0, 1'b0);
        run_drain(1, -1);

        rand_mats();
        load_mats(1, 1'b0);
        run_drain(2, -1);

        rand_mats();
        load_mats(2, 1'b0);
        run_drain(0, 5);
        reset_n = 1'b0;
        #1;
        chk_reset("midrst");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        rand_mats();
        load_mats(0, 1'b0);
        run_drain(2, -1);

        rand_mats();
        load_mats(0, 1'b1);
        run_drain(0, -1);

`ifdef MMU_CTRL_TIMEOUT_EN
        rand_mats();
        stub_dead = 1'b1;
        load_mats(0, 1'b0);
        cyc  = 0;
        sawv = 1'b0;
        while (mac_enable && cyc < 100) begin
            cyc++;
            if (out_valid) sawv = 1'b1;
            @(negedge clk);
        end
        check("tmo_cycles", cyc, 16);
        check("tmo_err", err, 1);
        check("tmo_idle", {in_ready, busy, out_valid}, 3'b100);
        check("tmo_no_valid", sawv, 0);
        stub_dead = 1'b0;
        rand_mats();
        load_mats(0, 1'b0);
        run_drain(0, -1);
`endif

        repeat (4) begin
            rand_mats();
            load_mats(2, 1'b0);
            run_drain(2, -1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
